// File: rtl/uart_ctl_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_t     : arbiter FSM encoding (IDLE, SEND, WAIT_DROP, WAIT_RISE)
//   DATA_W      : byte width carried to the transmitter
//   MAX_LEN_DEF : default cap on bytes sent per grant
package uart_ctl_pkg;

  localparam int DATA_W      = 8;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DROP = 2'd2,
    WAIT_RISE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index with highest priority this round (must be < N)
//   o_win : one-hot winner (all-zero when nothing requests)
//   o_vld : at least one request present
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_win,
  output logic             o_vld
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_win;
  logic [2*N-1:0] w_win_dbl;

  // Rotate so that i_ptr lands on bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into place.
  assign w_dbl     = {i_req, i_req} >> i_ptr;
  assign w_rot     = w_dbl[N-1:0];
  assign w_rot_win = w_rot & (~w_rot + N'(1));
  assign w_win_dbl = {{N{1'b0}}, w_rot_win} << i_ptr;
  assign o_win     = w_win_dbl[N-1:0] | w_win_dbl[2*N-1:N];
  assign o_vld     = |i_req;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into one UART
// transmitter. A grant is held for a whole message (until the byte flagged
// 'last') or until MAX_LEN bytes have been sent, then re-arbitrated.
//   clk, rst : clock, synchronous active-high reset
//   req/data/last : per-requester byte valid, byte, end-of-message flag
//   ack      : one-cycle pulse, granted requester's byte consumed
//   grant    : one-hot current owner, or zero
//   dout, tx_en : byte and start pulse to the transmitter
//   tx_rdy   : transmitter idle flag
//   busy     : FSM is not IDLE
// All outputs are registered.
module uart_tx_arb
  import uart_ctl_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [DATA_W*N_REQ-1:0]   data,
  input  logic [N_REQ-1:0]          last,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          grant,
  output logic [DATA_W-1:0]         dout,
  output logic                      tx_en,
  input  logic                      tx_rdy,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]  r_gidx, w_gidx_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [7:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic              r_last, w_last_nxt;
  logic [N_REQ-1:0]  r_ack, w_ack_nxt;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic              r_tx_en, w_tx_en_nxt;
  logic              r_busy;

  logic [N_REQ-1:0]  w_win;
  logic              w_win_vld;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_req_g;
  logic              w_last_g;
  logic [DATA_W-1:0] w_data_g;
  logic [IDX_W-1:0]  w_ptr_after;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (IDX_W)
  ) u_rr_pick (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_win (w_win),
    .o_vld (w_win_vld)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_win[i]) w_win_idx = IDX_W'(i);
  end

  // Owner's signals selected by AND-OR with the one-hot grant, so an
  // unknown byte on a non-granted lane is masked off before reaching dout.
  always_comb begin
    w_data_g = '0;
    for (int i = 0; i < N_REQ; i++)
      w_data_g = w_data_g | (data[i*DATA_W +: DATA_W] & {DATA_W{r_grant[i]}});
  end

  assign w_req_g     = |(req & r_grant);
  assign w_last_g    = |(last & r_grant);
  assign w_ptr_after = (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_gidx_nxt     = r_gidx;
    w_grant_nxt    = r_grant;
    w_byte_cnt_nxt = r_byte_cnt;
    w_last_nxt     = r_last;
    w_ack_nxt      = '0;
    w_dout_nxt     = r_dout;
    w_tx_en_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_grant_nxt    = w_win;
          w_gidx_nxt     = w_win_idx;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        if (!w_req_g) begin
          // Owner withdrew mid-message: give the bus away.
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = w_ptr_after;
          w_state_nxt  = IDLE;
        end else if (tx_rdy) begin
          w_tx_en_nxt    = 1'b1;
          w_dout_nxt     = w_data_g;
          w_ack_nxt      = r_grant;
          w_last_nxt     = w_last_g;
          w_byte_cnt_nxt = r_byte_cnt + 8'd1;
          w_state_nxt    = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        // Transmitter must first show it accepted the byte.
        if (!tx_rdy) w_state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (tx_rdy) begin
          if (r_last || (r_byte_cnt == 8'(MAX_LEN))) begin
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = w_ptr_after;
            w_state_nxt  = IDLE;
          end else begin
            w_state_nxt  = SEND;
          end
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_gidx     <= '0;
      r_grant    <= '0;
      r_byte_cnt <= '0;
      r_last     <= 1'b0;
      r_ack      <= '0;
      r_dout     <= '0;
      r_tx_en    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_gidx     <= w_gidx_nxt;
      r_grant    <= w_grant_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_last     <= w_last_nxt;
      r_ack      <= w_ack_nxt;
      r_dout     <= w_dout_nxt;
      r_tx_en    <= w_tx_en_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign ack   = r_ack;
  assign grant = r_grant;
  assign dout  = r_dout;
  assign tx_en = r_tx_en;
  assign busy  = r_busy;

endmodule
